// File: rtl/zigbee_cdr_param.sv
// rtl/zigbee_cdr_param.sv - clock/data recovery: phase discriminator, symbol integrate-and-dump, early/late timing and lock
module zigbee_cdr_param #(
    parameter int PHASE_W  = 6,
    parameter int OSR      = 8,
    parameter int LOCK_CNT = 8,
    parameter int LOCK_TOL = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      enable_i,
    input  logic signed [PHASE_W-1:0] phase_i,
    input  logic                      valid_i,
    output logic                      data_o,
    output logic                      valid_o,
    output logic                      lock_o
);

    localparam int CNT_W = $clog2(OSR);
    localparam int XW    = CNT_W + 1;
    localparam int ACC_W = PHASE_W + $clog2(OSR) + 1;
    localparam int LCK_W = $clog2(LOCK_CNT + 1);

    // Sample-position boundaries, one bit wider than cnt so LOCK_TOL=0 cannot wrap
    localparam logic [XW-1:0]    K_HOLD_HI = XW'(OSR / 2 - 1);
    localparam logic [XW-1:0]    K_ADV_LO  = XW'(OSR / 2 + 1);
    localparam logic [XW-1:0]    K_ADV_HI  = XW'(OSR - 2);
    localparam logic [XW-1:0]    K_LAST    = XW'(OSR - 1);
    localparam logic [XW-1:0]    K_TOL_LO  = XW'(LOCK_TOL);
    localparam logic [XW-1:0]    K_TOL_HI  = XW'(OSR - LOCK_TOL);
    localparam logic [LCK_W-1:0] LOCK_MAX  = LCK_W'(LOCK_CNT);

    logic signed [PHASE_W-1:0] phase_prev;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          cnt;
    logic                      first;
    logic                      prev_nz;
    logic                      prev_neg;
    logic                      corr_done;
    logic [LCK_W-1:0]          lock_cnt;
    logic                      data_q;
    logic                      valid_q;
    logic                      lock_q;

    logic signed [PHASE_W-1:0] dphi;
    logic                      dphi_nz;
    logic                      dphi_neg;
    logic                      trans;
    logic [XW-1:0]             k;
    logic                      in_hold;
    logic                      in_adv;
    logic                      in_tol;
    logic                      do_hold;
    logic                      do_adv;
    logic                      sym_end;
    logic signed [ACC_W-1:0]   acc_next;
    logic                      bit_next;
    logic [CNT_W-1:0]          cnt_next;
    logic [LCK_W-1:0]          lock_cnt_next;

    always_comb begin
        dphi     = phase_i - phase_prev;
        dphi_nz  = |dphi;
        dphi_neg = dphi[PHASE_W-1];
        acc_next = acc + {{(ACC_W - PHASE_W){dphi[PHASE_W-1]}}, dphi};
        bit_next = !acc_next[ACC_W-1] && (acc_next != '0);

        // A transition needs two opposite nonzero slopes; zero slopes are transparent
        trans = !first && dphi_nz && prev_nz && (dphi_neg != prev_neg);
        k     = {1'b0, cnt};

        in_hold = (k != '0) && (k <= K_HOLD_HI);
        in_adv  = (k >= K_ADV_LO) && (k <= K_ADV_HI);
        in_tol  = (k <= K_TOL_LO) || (k >= K_TOL_HI);
        do_hold = trans && !corr_done && in_hold;
        do_adv  = trans && !corr_done && in_adv;

        // An advance from OSR-2 lands on the last position, closing the symbol now
        sym_end = (k == K_LAST) || (do_adv && (k == K_ADV_HI));

        cnt_next = '0;
        if (!sym_end) begin
            if (do_hold) begin
                cnt_next = cnt;
            end else if (do_adv) begin
                cnt_next = cnt + CNT_W'(2);
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end

        lock_cnt_next = lock_cnt;
        if (trans) begin
            if (!in_tol) begin
                lock_cnt_next = '0;
            end else if (lock_cnt != LOCK_MAX) begin
                lock_cnt_next = lock_cnt + LCK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_prev <= '0;
            acc        <= '0;
            cnt        <= '0;
            first      <= 1'b1;
            prev_nz    <= 1'b0;
            prev_neg   <= 1'b0;
            corr_done  <= 1'b0;
            lock_cnt   <= '0;
            data_q     <= 1'b0;
            valid_q    <= 1'b0;
            lock_q     <= 1'b0;
        end else if (!enable_i) begin
            phase_prev <= '0;
            acc        <= '0;
            cnt        <= '0;
            first      <= 1'b1;
            prev_nz    <= 1'b0;
            prev_neg   <= 1'b0;
            corr_done  <= 1'b0;
            lock_cnt   <= '0;
            data_q     <= 1'b0;
            valid_q    <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (valid_i) begin
                phase_prev <= phase_i;
                if (first) begin
                    first <= 1'b0;
                end else begin
                    if (dphi_nz) begin
                        prev_nz  <= 1'b1;
                        prev_neg <= dphi_neg;
                    end
                    lock_cnt <= lock_cnt_next;
                    lock_q   <= (lock_cnt_next == LOCK_MAX);
                    cnt      <= cnt_next;
                    if (do_hold || do_adv) begin
                        corr_done <= 1'b1;
                    end
                    if (sym_end) begin
                        data_q    <= bit_next;
                        valid_q   <= 1'b1;
                        acc       <= '0;
                        corr_done <= 1'b0;
                    end else begin
                        acc <= acc_next;
                    end
                end
            end
        end
    end

    // Soft disable silences the outputs in the same cycle, ahead of the clear edge
    assign data_o  = data_q & enable_i;
    assign valid_o = valid_q & enable_i;
    assign lock_o  = lock_q & enable_i;

endmodule

// File: tb/tb_zigbee_cdr_param.sv
// tb/tb_zigbee_cdr_param.sv - directed bench for zigbee_cdr_param with a per-sample behavioural model
module tb_zigbee_cdr_param;
    localparam int PW   = 6;
    localparam int OSR  = 8;
    localparam int LCNT = 8;
    localparam int LTOL = 1;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 enable_i = 1'b0;
    logic                 valid_i = 1'b0;
    logic signed [PW-1:0] phase_i = '0;
    logic                 data_o;
    logic                 valid_o;
    logic                 lock_o;

    zigbee_cdr_param #(.PHASE_W(PW), .OSR(OSR), .LOCK_CNT(LCNT), .LOCK_TOL(LTOL)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .enable_i (enable_i),
        .phase_i  (phase_i),
        .valid_i  (valid_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .lock_o   (lock_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int m_acc, m_cnt, m_prev, m_ps, m_lc;
    bit m_first, m_cd, m_data, m_vo, m_lock;

    int samp;
    int pulse_at[$];
    bit pulse_bits[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrapp(int x);
        int m;
        m = 1 << PW;
        return ((x % m) + m + m / 2) % m - m / 2;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_prev = 0; m_ps = 0; m_lc = 0;
        m_first = 1'b1; m_cd = 1'b0; m_data = 1'b0; m_vo = 1'b0; m_lock = 1'b0;
    endtask

    // Symbol positions: a sample sits at position pos; the next sample takes position nxt
    task automatic model_step(bit en, bit v, int ph);
        int d, s, k, pos, nxt;
        bit tr;
        if (!resetn || !en) begin
            model_reset();
            return;
        end
        m_vo = 1'b0;
        if (!v) return;
        if (m_first) begin
            m_first = 1'b0;
            m_prev  = wrapp(ph);
            return;
        end
        d      = wrapp(ph - m_prev);
        m_prev = wrapp(ph);
        s      = (d > 0) ? 1 : ((d < 0) ? -1 : 0);
        tr     = (s != 0) && (m_ps != 0) && (s != m_ps);
        if (s != 0) m_ps = s;
        k   = m_cnt;
        pos = k;
        nxt = k + 1;
        if (tr) begin
            if (k <= LTOL || k >= OSR - LTOL) m_lc = (m_lc < LCNT) ? m_lc + 1 : LCNT;
            else m_lc = 0;
            if (!m_cd && k >= 1 && k <= OSR / 2 - 1) begin
                nxt = k; m_cd = 1'b1;
            end else if (!m_cd && k >= OSR / 2 + 1 && k <= OSR - 2) begin
                pos = k + 1; nxt = k + 2; m_cd = 1'b1;
            end
        end
        m_lock = (m_lc == LCNT);
        m_acc  = m_acc + d;
        if (pos == OSR - 1) begin
            m_data = (m_acc > 0);
            m_vo   = 1'b1;
            m_acc  = 0;
            m_cnt  = 0;
            m_cd   = 1'b0;
        end else begin
            m_cnt = nxt;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_data_o", data_o, m_data & enable_i);
            chk("cmp_valid_o", valid_o, m_vo & enable_i);
            chk("cmp_lock_o", lock_o, m_lock & enable_i);
        end
    end

    task automatic cyc(bit en, bit v, int ph);
        enable_i = en;
        valid_i  = v;
        phase_i  = PW'(ph);
        @(posedge clk);
        model_step(en, v, ph);
        #1;
        if (en && v) samp++;
        if (valid_o) begin
            pulse_at.push_back(samp);
            pulse_bits.push_back(data_o);
        end
    endtask

    task automatic clear_tally();
        samp = 0;
        pulse_at.delete();
        pulse_bits.delete();
    endtask

    function automatic int sign_t5(int j);
        if (j < 3) return -1;
        if (j >= 87 && j <= 90) return -1;
        return (((j - 3) / 8) % 2 == 0) ? 1 : -1;
    endfunction

    initial begin
        int ph;
        model_reset();
        clear_tally();
        chk_en = 1'b1;

        // Reset held while valid_i toggles
        for (int i = 0; i < 6; i++) cyc(1'b1, i[0], i * 3);
        chk("rst_hold_outputs", {29'd0, data_o, valid_o, lock_o}, 32'd0);
        resetn = 1'b1;

        // Positive ramp: first pulse on 9th valid sample, then every 8
        cyc(1'b0, 1'b0, 0);
        clear_tally();
        ph = 0;
        for (int i = 0; i < 41; i++) begin
            cyc(1'b1, 1'b1, ph);
            ph += 3;
        end
        chk("t2_n_pulses", pulse_at.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_pulse_pos", pulse_at[i], 9 + 8 * i);
            chk("t2_bit", pulse_bits[i], 1);
        end
        chk("t2_lock", lock_o, 0);

        // Wrap across +31/-32 in both directions
        cyc(1'b0, 1'b0, 0);
        clear_tally();
        ph = 24;
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 1'b1, ph);
            ph += 3;
        end
        chk("t3_up_n", pulse_at.size(), 2);
        chk("t3_up_b0", pulse_bits[0], 1);
        chk("t3_up_b1", pulse_bits[1], 1);
        cyc(1'b0, 1'b0, 0);
        clear_tally();
        ph = -20;
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 1'b1, ph);
            ph -= 3;
        end
        chk("t3_dn_n", pulse_at.size(), 2);
        chk("t3_dn_b0", pulse_bits[0], 0);
        chk("t3_dn_b1", pulse_bits[1], 0);

        // Aligned alternating bits, valid every 5th cycle
        cyc(1'b0, 1'b0, 0);
        clear_tally();
        ph = 0;
        cyc(1'b1, 1'b1, ph);
        for (int g = 0; g < 4; g++) cyc(1'b1, 1'b0, ph);
        for (int s = 0; s < 11; s++) begin
            for (int j = 0; j < 8; j++) begin
                ph += (s % 2 == 0) ? 3 : -3;
                cyc(1'b1, 1'b1, ph);
                if (s >= 1 && j == 0) chk("t4_lock_after_trans", lock_o, (s >= 8) ? 1 : 0);
                for (int g = 0; g < 4; g++) cyc(1'b1, 1'b0, ph);
            end
        end
        chk("t4_n", pulse_bits.size(), 11);
        for (int i = 0; i < 11; i++) chk("t4_bit", pulse_bits[i], (i % 2 == 0) ? 1 : 0);

        // Asynchronous reset mid-symbol
        for (int j = 0; j < 3; j++) begin
            ph += 3;
            cyc(1'b1, 1'b1, ph);
        end
        chk("t1_pre_async_lock", lock_o, 1);
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("t1_async_outputs", {29'd0, data_o, valid_o, lock_o}, 32'd0);
        cyc(1'b1, 1'b1, ph);
        cyc(1'b1, 1'b0, ph);
        resetn = 1'b1;

        // Offset by 3 samples: hold corrections pull into alignment, then a k=4 transition
        cyc(1'b0, 1'b0, 0);
        clear_tally();
        ph = 0;
        cyc(1'b1, 1'b1, ph);
        for (int j = 0; j < 99; j++) begin
            ph += 3 * sign_t5(j);
            cyc(1'b1, 1'b1, ph);
            if (j == 74) chk("t5_lock_pre", lock_o, 0);
            if (j == 75) chk("t5_lock_rise", lock_o, 1);
            if (j == 86) chk("t5_lock_held", lock_o, 1);
            if (j == 87) chk("t5_lock_drop", lock_o, 0);
        end
        chk("t5_pulse0", pulse_at[0], 10);
        chk("t5_pulse1", pulse_at[1], 19);
        chk("t5_pulse2", pulse_at[2], 28);
        chk("t5_pulse3", pulse_at[3], 36);
        chk("t5_bit0", pulse_bits[0], 1);
        chk("t5_bit1", pulse_bits[1], 0);
        chk("t5_bit2", pulse_bits[2], 1);
        chk("t5_bit3", pulse_bits[3], 0);

        // Soft clear at cnt=5 with valid_i high
        cyc(1'b0, 1'b0, 0);
        clear_tally();
        ph = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, ph);
            ph += 3;
        end
        cyc(1'b0, 1'b1, ph);
        ph += 3;
        chk("t6_no_pulse_before", pulse_at.size(), 0);
        clear_tally();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, ph);
            ph += 3;
        end
        chk("t6_n", pulse_at.size(), 2);
        chk("t6_first_pulse", pulse_at[0], 9);
        chk("t6_second_pulse", pulse_at[1], 17);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
